aoi_out_logger: RTL and testbench

Downstream capture stage for the `aoi4i` gate block. Each clock it samples the block's three outputs `e`, `f`, `g` and detects any change against the previous sample. Every change is written as a timestamped record into a small FIFO, which a consumer drains through a valid/ready port. The block also keeps saturating per-output toggle counters and a sticky overflow flag.

---
 rtl/aoi_out_logger.sv | 149 ++++++++++++++
 tb/tb_aoi_out_logger.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aoi_out_logger.sv
// aoi_out_logger: change logger for the aoi4i outputs e/f/g.
//
// Each cycle {e,f,g} is sampled (when en=1). Any change against the last logged
// sample is pushed as a timestamped record {ts, e, f, g} into a DEPTH-entry FIFO.
// The FIFO is drained through a valid/ready port. Per-output toggle counters
// saturate, and a sticky overflow flag marks dropped records.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  sample enable
//   e, f, g             AOI stage outputs
//   clr                 clears toggle counters and overflow (FIFO untouched)
//   out_valid/out_ready head record handshake
//   out_data            {ts, e, f, g}, g at bit 0; zero while empty
//   level               FIFO occupancy
//   overflow            sticky drop flag
//   e_cnt/f_cnt/g_cnt   saturating toggle counters
module aoi_out_logger #(
  parameter int unsigned TW    = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    e,
  input  logic                    f,
  input  logic                    g,
  input  logic                    clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TW+2:0]           out_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CW-1:0]           e_cnt,
  output logic [CW-1:0]           f_cnt,
  output logic [CW-1:0]           g_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = TW + 3;

  logic [TW-1:0] ts_q;
  logic [2:0]    s1_q;
  logic          s1_vld_q;
  logic [2:0]    prev_q;
  logic          primed_q;
  logic [RW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          overflow_q;
  logic [CW-1:0] e_cnt_q;
  logic [CW-1:0] f_cnt_q;
  logic [CW-1:0] g_cnt_q;

  logic [2:0] diff;
  logic       rec_push;
  logic       is_change;
  logic       full;
  logic       pop;
  logic       wr_en;
  logic       drop;

  always_comb begin
    diff      = s1_q ^ prev_q;
    // First valid sample after reset is always logged as the baseline.
    rec_push  = s1_vld_q && (!primed_q || (diff != 3'b000));
    is_change = s1_vld_q && primed_q && (diff != 3'b000);
    full      = (level_q == (AW + 1)'(DEPTH));
    pop       = (level_q != '0) && out_ready;
    // When full, a simultaneous pop frees the slot the write lands in.
    wr_en     = rec_push && (!full || pop);
    drop      = rec_push && full && !pop;
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      s1_q       <= '0;
      s1_vld_q   <= 1'b0;
      prev_q     <= '0;
      primed_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      e_cnt_q    <= '0;
      f_cnt_q    <= '0;
      g_cnt_q    <= '0;
    end else begin
      ts_q <= ts_q + TW'(1);

      if (en) begin
        s1_q     <= {e, f, g};
        s1_vld_q <= 1'b1;
      end

      // prev tracks the detected sample even when the record itself is dropped.
      if (rec_push) begin
        prev_q   <= s1_q;
        primed_q <= 1'b1;
      end

      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);

      if (wr_en && !pop) begin
        level_q <= level_q + (AW + 1)'(1);
      end else if (pop && !wr_en) begin
        level_q <= level_q - (AW + 1)'(1);
      end

      if (clr) begin
        overflow_q <= 1'b0;
        e_cnt_q    <= '0;
        f_cnt_q    <= '0;
        g_cnt_q    <= '0;
      end else begin
        if (drop) overflow_q <= 1'b1;
        if (is_change) begin
          if (diff[2]) e_cnt_q <= sat_inc(e_cnt_q);
          if (diff[1]) f_cnt_q <= sat_inc(f_cnt_q);
          if (diff[0]) g_cnt_q <= sat_inc(g_cnt_q);
        end
      end
    end
  end

  // Storage needs no reset: entries are only visible through level.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ts_q, s1_q};
  end

  always_comb begin
    out_valid = (level_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    level     = level_q;
    overflow  = overflow_q;
    e_cnt     = e_cnt_q;
    f_cnt     = f_cnt_q;
    g_cnt     = g_cnt_q;
  end

endmodule

// File: tb/tb_aoi_out_logger.sv
// Bench for aoi_out_logger: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model of the logging rules.
module tb_aoi_out_logger;

  localparam int unsigned TW    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 2;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          e;
  logic          f;
  logic          g;
  logic          clr;
  logic          out_valid;
  logic          out_ready;
  logic [TW+2:0] out_data;
  logic [3:0]    level;
  logic          overflow;
  logic [CW-1:0] e_cnt;
  logic [CW-1:0] f_cnt;
  logic [CW-1:0] g_cnt;

  aoi_out_logger #(
    .TW   (TW),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .e        (e),
    .f        (f),
    .g        (g),
    .clr      (clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level),
    .overflow (overflow),
    .e_cnt    (e_cnt),
    .f_cnt    (f_cnt),
    .g_cnt    (g_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state.
  bit              m_init = 1'b0;
  int              m_ts;
  logic [2:0]      m_s1;
  bit              m_s1v;
  logic [2:0]      m_prev;
  bit              m_primed;
  logic [TW+2:0]   m_q[$];
  bit              m_ovf;
  int              m_cnt[3];

  logic [2:0] ov_vals[10] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100,
                              3'b101, 3'b110, 3'b111, 3'b000, 3'b001};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_outputs();
    check("valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("level", 32'(level), m_q.size());
    check("data", 32'(out_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("e_cnt", 32'(e_cnt), m_cnt[0]);
    check("f_cnt", 32'(f_cnt), m_cnt[1]);
    check("g_cnt", 32'(g_cnt), m_cnt[2]);
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic r, input logic en_v, input logic [2:0] efg_v,
                            input logic clr_v, input logic rdy);
    bit            push;
    logic [TW+2:0] rec;
    if (r) begin
      m_ts = 0; m_s1 = '0; m_s1v = 0; m_prev = '0; m_primed = 0;
      m_q.delete(); m_ovf = 0; m_cnt = '{0, 0, 0}; m_init = 1'b1;
      return;
    end
    push = 0;
    rec  = '0;
    if (m_s1v) begin
      if (!m_primed) begin
        push = 1; rec = {TW'(m_ts), m_s1}; m_prev = m_s1; m_primed = 1;
      end else if (m_s1 != m_prev) begin
        for (int i = 0; i < 3; i++) begin
          if (m_s1[2-i] != m_prev[2-i] && m_cnt[i] < CMAX) m_cnt[i]++;
        end
        push = 1; rec = {TW'(m_ts), m_s1}; m_prev = m_s1;
      end
    end
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(rec);
      else m_ovf = 1;
    end
    if (clr_v) begin
      m_ovf = 0; m_cnt = '{0, 0, 0};
    end
    m_ts = (m_ts + 1) % (1 << TW);
    if (en_v) begin
      m_s1 = efg_v; m_s1v = 1;
    end
  endtask

  task automatic cycle(input logic r, input logic en_v, input logic [2:0] efg_v,
                       input logic clr_v, input logic rdy);
    rst = r; en = en_v; {e, f, g} = efg_v; clr = clr_v; out_ready = rdy;
    if (m_init) compare_outputs();
    model_step(r, en_v, efg_v, clr_v, rdy);
    @(posedge clk);
    #1;
    cyc = r ? 0 : cyc + 1;
  endtask

  initial begin
    logic [2:0] v;
    logic [2:0] lastv;
    int         bias;

    // Reset with random inputs.
    repeat (3) cycle(1'b1, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    check("rst_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_cnt", 32'({e_cnt, f_cnt, g_cnt}), 0);

    // Baseline, then two single changes.
    for (int k = 0; k < 24; k++) begin
      v = (k < 10) ? 3'b101 : (k < 20) ? 3'b001 : 3'b110;
      if (k == 2) begin
        check("base_valid", 32'(out_valid), 1);
        check("base_data", 32'(out_data), 32'({4'd1, 3'b101}));
      end
      if (k == 9) begin
        check("base_level", 32'(level), 1);
        check("base_cnt", 32'({e_cnt, f_cnt, g_cnt}), 0);
      end
      if (k == 12) begin
        check("chg1_data", 32'(out_data), 32'({4'd11, 3'b001}));
        check("chg1_e", 32'(e_cnt), 1);
        check("chg1_fg", 32'({f_cnt, g_cnt}), 0);
      end
      if (k == 22) begin
        check("chg2_data", 32'(out_data), 32'({4'd5, 3'b110}));
        check("chg2_cnt", 32'({e_cnt, f_cnt, g_cnt}), 32'({2'd2, 2'd1, 2'd1}));
      end
      cycle(1'b0, 1'b1, v, 1'b0, k >= 10);
    end

    // Reset while three records are held.
    cycle(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) check("r3_level", 32'(level), 3);
      cycle(k == 4, 1'b1, (k == 1) ? 3'b111 : 3'b000, 1'b0, 1'b0);
    end
    check("r3_level0", 32'(level), 0);
    check("r3_valid0", 32'(out_valid), 0);

    // Overflow, clr, then push+pop while full, then drain.
    cycle(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      v = (k < 10) ? ov_vals[k] : (k < 13) ? ov_vals[9] : 3'b110;
      if (k == 12) begin
        check("ovf_level", 32'(level), 8);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_head", 32'(out_data), 32'({4'd1, 3'b000}));
      end
      if (k == 13) begin
        check("clr_ovf", 32'(overflow), 0);
        check("clr_cnt", 32'({e_cnt, f_cnt, g_cnt}), 0);
        check("clr_level", 32'(level), 8);
      end
      if (k == 15) begin
        check("pp_level", 32'(level), 8);
        check("pp_ovf", 32'(overflow), 0);
        check("pp_head", 32'(out_data), 32'({4'd2, 3'b001}));
      end
      cycle(1'b0, 1'b1, v, k == 12, k >= 14);
    end

    // Timestamp wrap.
    cycle(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 18; k++) begin
      if (k == 17) check("wrap_data", 32'(out_data), 32'({4'd0, 3'b001}));
      cycle(1'b0, 1'b1, (k < 15) ? 3'b000 : 3'b001, 1'b0, k < 15);
    end

    // Enable gating, then saturation of e_cnt.
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, {k[0], 2'b01}, 1'b0, 1'b1);
    check("gate_valid", 32'(out_valid), 0);
    check("gate_ecnt", 32'(e_cnt), 0);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, {k[0], 2'b01}, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b1, 3'b101, 1'b0, 1'b1);
    check("sat_ecnt", 32'(e_cnt), 3);

    // Randomized traffic.
    cycle(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    lastv = 3'($urandom);
    bias  = 2;
    for (int k = 0; k < 2000; k++) begin
      if (k % 64 == 0) bias = $urandom_range(4);
      if ($urandom_range(1) == 0) lastv = 3'($urandom);
      cycle($urandom_range(149) == 0, $urandom_range(3) != 0, lastv,
            $urandom_range(39) == 0, $urandom_range(3) < bias);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
